// File: rtl/pu_fault_pkg.sv
// Fault mode codes and the word transform shared by the fault-injecting PU and its testbenches.
package pu_fault_pkg;
    localparam int FAULT_NONE  = 0;
    localparam int FAULT_ADD   = 1;
    localparam int FAULT_XOR   = 2;
    localparam int FAULT_STUCK = 3;
    localparam int FAULT_DUP   = 4;

    // Widest {attr, data} word the transform handles; callers truncate the result to their width.
    localparam int FW_MAX = 64;

    function automatic logic [FW_MAX-1:0] fault_apply(input int mode,
                                                      input logic [FW_MAX-1:0] op,
                                                      input logic [FW_MAX-1:0] word);
        logic [FW_MAX-1:0] res;
        case (mode)
            FAULT_ADD:   res = word + op;
            FAULT_XOR:   res = word ^ op;
            FAULT_STUCK: res = op;
            default:     res = word;
        endcase
        return res;
    endfunction
endpackage

// File: rtl/pu_broken_fifo_if.sv
// Bus-side signals of the fault-injecting PU: write port, pop request, registered read port and status.
interface pu_broken_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4
);
    logic                  signal_wr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ATTR_WIDTH-1:0] attr_in;
    logic                  signal_oe;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ATTR_WIDTH-1:0] attr_out;
    logic                  full;
    logic                  empty;
    logic                  err;
    logic                  fault_hit;

    modport master (output signal_wr, data_in, attr_in, signal_oe,
                    input  data_out, attr_out, full, empty, err, fault_hit);
    modport slave  (input  signal_wr, data_in, attr_in, signal_oe,
                    output data_out, attr_out, full, empty, err, fault_hit);
endinterface

// File: rtl/pu_fifo_bank.sv
// Circular-buffer FIFO; push/pop arrive pre-qualified, hold_i keeps the head word in place on a pop.
module pu_fifo_bank #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         hold_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          adv;

    always_comb begin
        adv    = pop_i && !hold_i;
        head_d = adv    ? head_q + 1'b1 : head_q;
        tail_d = push_i ? tail_q + 1'b1 : tail_q;
        cnt_d  = cnt_q + (PW+1)'(push_i) - (PW+1)'(adv);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // When full, tail == head: the head is read before this edge overwrites it.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[tail_q] <= din_i;
    end

    assign head_o  = mem_q[head_q];
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/pu_broken_fifo.sv
// FIFO processing unit that corrupts popped words once a programmable number of clean pops has passed.
module pu_broken_fifo
    import pu_fault_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ATTR_WIDTH  = 4,
    parameter int          DEPTH       = 4,
    parameter int          FAULT_MODE  = FAULT_NONE,
    parameter logic [63:0] FAULT_VALUE = 64'd1,
    parameter int          FAULT_AFTER = 0,
    parameter int          FAULT_ONCE  = 0
) (
    input logic             clk,
    input logic             rst_n,
    pu_broken_fifo_if.slave bus
);
    localparam int          W     = DATA_WIDTH + ATTR_WIDTH;
    localparam logic [W-1:0] FV   = W'(FAULT_VALUE);
    localparam logic [31:0] AFTER = 32'(FAULT_AFTER);
    localparam logic [31:0] SAT   = 32'(FAULT_AFTER + 1);

    logic [W-1:0]      head_w;
    logic              bank_full, bank_empty;
    logic              pop_ok, fault_act, hold, adv, push_ok;
    logic [FW_MAX-1:0] xf;
    logic [31:0]       pops_q, pops_d;
    logic [W-1:0]      out_q, out_d;
    logic              hit_q, hit_d, err_q, err_d;

    always_comb begin
        pop_ok = bus.signal_oe && !bank_empty;
        if (FAULT_MODE == FAULT_NONE) fault_act = 1'b0;
        else if (FAULT_ONCE != 0)     fault_act = (pops_q == AFTER);
        else                          fault_act = (pops_q >= AFTER);
        hold    = fault_act && (FAULT_MODE == FAULT_DUP);
        adv     = pop_ok && !hold;
        // A held duplicate pop frees no slot, so it cannot make room for a write.
        push_ok = bus.signal_wr && (!bank_full || adv);
        xf      = fault_apply(FAULT_MODE, FW_MAX'(FV), FW_MAX'(head_w));

        out_d = '0;
        hit_d = 1'b0;
        if (pop_ok) begin
            out_d = fault_act ? xf[W-1:0] : head_w;
            hit_d = fault_act;
        end
        pops_d = (pop_ok && pops_q != SAT) ? pops_q + 32'd1 : pops_q;
        err_d  = err_q | (bus.signal_wr && !push_ok) | (bus.signal_oe && bank_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pops_q <= '0;
            out_q  <= '0;
            hit_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pops_q <= pops_d;
            out_q  <= out_d;
            hit_q  <= hit_d;
            err_q  <= err_d;
        end
    end

    pu_fifo_bank #(.W(W), .DEPTH(DEPTH)) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_ok),
        .pop_i   (pop_ok),
        .hold_i  (hold),
        .din_i   ({bus.attr_in, bus.data_in}),
        .head_o  (head_w),
        .full_o  (bank_full),
        .empty_o (bank_empty)
    );

    assign bus.data_out  = out_q[DATA_WIDTH-1:0];
    assign bus.attr_out  = out_q[W-1:DATA_WIDTH];
    assign bus.full      = bank_full;
    assign bus.empty     = bank_empty;
    assign bus.err       = err_q;
    assign bus.fault_hit = hit_q;
endmodule
